// File: rtl/key_search_ctrl_if.sv
// Handshake and plaintext-read bundle between key_search_ctrl, its arc4 core and the cracker top.
interface key_search_ctrl_if;
    logic        en;
    logic        rdy;
    logic [23:0] key;
    logic        key_valid;
    logic        arc4_en;
    logic        arc4_rdy;
    logic [23:0] arc4_key;
    logic        pt_sel;
    logic [7:0]  scan_addr;
    logic [7:0]  scan_rddata;

    modport master (
        input  en, arc4_rdy, scan_rddata,
        output rdy, key, key_valid, arc4_en, arc4_key, pt_sel, scan_addr
    );

    modport slave (
        output en, arc4_rdy, scan_rddata,
        input  rdy, key, key_valid, arc4_en, arc4_key, pt_sel, scan_addr
    );
endinterface

// File: rtl/key_search_ctrl.sv
// ARC4 key-space walker: one arc4 run per candidate key, then a printable-ASCII scan of the plaintext.
// Optional feature macro: KEY_SEARCH_EARLY_ABORT_EN (stop scanning at the first bad byte).
//
// state      | meaning
// IDLE       | rdy=1, waiting for en
// ARC4_START | wait for arc4_rdy, then pulse arc4_en
// ARC4_ACK   | dead cycle while arc4 drops rdy
// ARC4_RUN   | wait for arc4 to finish
// LEN_REQ    | plaintext port taken, address 0 on the bus
// LEN_WAIT   | latch message length from byte 0
// SCAN       | pipelined read/check of bytes 1..len
// NEXT_KEY   | advance key or give up at end of key space
// DONE       | publish result, return to IDLE
module key_search_ctrl #(
    parameter logic [23:0] KEY_START = 24'h000000,
    parameter logic [23:0] KEY_STEP  = 24'h000001,
    parameter logic [23:0] KEY_MAX   = 24'hFFFFFF
) (
    input logic               clk,
    input logic               rst_n,
    key_search_ctrl_if.master bus
);

    localparam logic [3:0] S_IDLE       = 4'd0;
    localparam logic [3:0] S_ARC4_START = 4'd1;
    localparam logic [3:0] S_ARC4_ACK   = 4'd2;
    localparam logic [3:0] S_ARC4_RUN   = 4'd3;
    localparam logic [3:0] S_LEN_REQ    = 4'd4;
    localparam logic [3:0] S_LEN_WAIT   = 4'd5;
    localparam logic [3:0] S_SCAN       = 4'd6;
    localparam logic [3:0] S_NEXT_KEY   = 4'd7;
    localparam logic [3:0] S_DONE       = 4'd8;

    logic [3:0]  state;
    logic        rdy_r;
    logic [23:0] key_r;
    logic        key_valid_r;
    logic        arc4_en_r;
    logic        pt_sel_r;
    logic [7:0]  scan_addr_r;
    logic [7:0]  msg_len;
    logic [7:0]  cyc;
    logic        bad;
    logic        hit;

    logic        byte_bad;
    logic [24:0] key_sum;

    // cyc is the index of the byte whose data is on scan_rddata; 0 means nothing to check yet
    assign byte_bad = (cyc != 8'd0) && ((bus.scan_rddata < 8'h20) || (bus.scan_rddata > 8'h7E));
    assign key_sum  = {1'b0, key_r} + {1'b0, KEY_STEP};

    assign bus.rdy       = rdy_r;
    assign bus.key       = key_r;
    assign bus.arc4_key  = key_r;
    assign bus.key_valid = key_valid_r;
    assign bus.arc4_en   = arc4_en_r;
    assign bus.pt_sel    = pt_sel_r;
    assign bus.scan_addr = scan_addr_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            rdy_r       <= 1'b1;
            key_r       <= KEY_START;
            key_valid_r <= 1'b0;
            arc4_en_r   <= 1'b0;
            pt_sel_r    <= 1'b0;
            scan_addr_r <= 8'd0;
            msg_len     <= 8'd0;
            cyc         <= 8'd0;
            bad         <= 1'b0;
            hit         <= 1'b0;
        end else begin
            arc4_en_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.en) begin
                        rdy_r       <= 1'b0;
                        key_valid_r <= 1'b0;
                        key_r       <= KEY_START;
                        hit         <= 1'b0;
                        state       <= S_ARC4_START;
                    end
                end
                S_ARC4_START: begin
                    if (bus.arc4_rdy) begin
                        arc4_en_r <= 1'b1;
                        state     <= S_ARC4_ACK;
                    end
                end
                S_ARC4_ACK: state <= S_ARC4_RUN;
                S_ARC4_RUN: begin
                    if (bus.arc4_rdy) begin
                        pt_sel_r    <= 1'b1;
                        scan_addr_r <= 8'd0;
                        state       <= S_LEN_REQ;
                    end
                end
                S_LEN_REQ: state <= S_LEN_WAIT;
                S_LEN_WAIT: begin
                    msg_len <= bus.scan_rddata;
                    if (bus.scan_rddata == 8'd0) begin
                        pt_sel_r <= 1'b0;
                        hit      <= 1'b1;
                        state    <= S_DONE;
                    end else begin
                        scan_addr_r <= 8'd1;
                        cyc         <= 8'd0;
                        bad         <= 1'b0;
                        state       <= S_SCAN;
                    end
                end
                S_SCAN: begin
`ifdef KEY_SEARCH_EARLY_ABORT_EN
                    if (byte_bad) begin
                        pt_sel_r <= 1'b0;
                        state    <= S_NEXT_KEY;
                    end else
`endif
                    if (cyc == msg_len) begin
                        pt_sel_r <= 1'b0;
                        if (bad || byte_bad) begin
                            state <= S_NEXT_KEY;
                        end else begin
                            hit   <= 1'b1;
                            state <= S_DONE;
                        end
                    end else begin
                        cyc <= cyc + 8'd1;
                        bad <= bad | byte_bad;
                        if (scan_addr_r != msg_len) scan_addr_r <= scan_addr_r + 8'd1;
                    end
                end
                S_NEXT_KEY: begin
                    if (key_sum[24] || (key_sum > {1'b0, KEY_MAX})) begin
                        state <= S_DONE;
                    end else begin
                        key_r <= key_sum[23:0];
                        state <= S_ARC4_START;
                    end
                end
                S_DONE: begin
                    rdy_r       <= 1'b1;
                    key_valid_r <= hit;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
